gen_mem8_resp: RTL



---
 rtl/gen_mem8_resp_if.sv | 20 ++
 rtl/gen_mem8_resp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gen_mem8_resp_if.sv
// rtl/gen_mem8_resp_if.sv - dev_* req/ack bus between the arbiter and the 8-bit memory responder
interface gen_mem8_resp_if;
   logic [31:0] dev_addr;
   logic [31:0] dev_wdata;
   logic [3:0]  dev_be;
   logic        dev_wr;
   logic        dev_req;
   logic        dev_ack;
   logic [31:0] dev_rdata;

   modport master (
      output dev_addr, dev_wdata, dev_be, dev_wr, dev_req,
      input  dev_ack, dev_rdata
   );

   modport slave (
      input  dev_addr, dev_wdata, dev_be, dev_wr, dev_req,
      output dev_ack, dev_rdata
   );
endinterface

// File: rtl/gen_mem8_resp.sv
// rtl/gen_mem8_resp.sv - dev_* slave that turns each request into one timed byte access on an async 8-bit SRAM/flash bus
module gen_mem8_resp #(
   parameter int p_awidth = 20,
   parameter int p_tsu    = 1,
   parameter int p_twait  = 4,
   parameter int p_thold  = 1,
   parameter int p_trec   = 1
) (
   input  logic                dev_clk,
   input  logic                dev_rst_n,
   gen_mem8_resp_if.slave      dev,
   output logic [p_awidth-1:0] mem_a,
   output logic [7:0]          mem_dq_o,
   output logic                mem_dq_oe,
   input  logic [7:0]          mem_dq_i,
   output logic                mem_ce_n,
   output logic                mem_oe_n,
   output logic                mem_we_n
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STROBE = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_ACK    = 3'd4;
   localparam logic [2:0] S_RECOV  = 3'd5;

   localparam logic [3:0] TSU   = 4'(p_tsu);
   localparam logic [3:0] TWAIT = 4'(p_twait);
   localparam logic [3:0] THOLD = 4'(p_thold);
   localparam logic [3:0] TREC  = 4'(p_trec);
   localparam bit HAS_HOLD = (p_thold > 0);
   localparam bit HAS_REC  = (p_trec > 0);

   logic [2:0]          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                ack_q, ack_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [p_awidth-1:0] a_q, a_d;
   logic [7:0]          dqo_q, dqo_d;
   logic                dqoe_q, dqoe_d;
   logic                ce_n_q, ce_n_d;
   logic                oe_n_q, oe_n_d;
   logic                we_n_q, we_n_d;
   logic                wr_q, wr_d;
   logic                wen_q, wen_d;
   logic [1:0]          lane;

   assign lane = dev.dev_addr[1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = ack_q;
      rdata_d = rdata_q;
      a_d     = a_q;
      dqo_d   = dqo_q;
      dqoe_d  = dqoe_q;
      ce_n_d  = ce_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      wr_d    = wr_q;
      wen_d   = wen_q;
      case (state_q)
         S_IDLE: begin
            if (dev.dev_req) begin
               a_d     = dev.dev_addr[p_awidth-1:0];
               wr_d    = dev.dev_wr;
               dqo_d   = 8'(dev.dev_wdata >> {lane, 3'b000});
               wen_d   = dev.dev_be[lane];
               ce_n_d  = 1'b0;
               dqoe_d  = dev.dev_wr;
               state_d = S_SETUP;
               cnt_d   = TSU;
            end
         end
         S_SETUP: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_STROBE;
               cnt_d   = TWAIT;
               oe_n_d  = wr_q;
               // A masked write still runs full timing, just without WE_n
               we_n_d  = !(wr_q && wen_q);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_STROBE: begin
            if (cnt_q <= 4'd1) begin
               oe_n_d = 1'b1;
               we_n_d = 1'b1;
               if (!wr_q) rdata_d = {4{mem_dq_i}};
               if (HAS_HOLD) begin
                  state_d = S_HOLD;
                  cnt_d   = THOLD;
               end else begin
                  state_d = S_ACK;
                  cnt_d   = 4'd0;
                  ack_d   = 1'b1;
                  ce_n_d  = 1'b1;
                  dqoe_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_ACK;
               cnt_d   = 4'd0;
               ack_d   = 1'b1;
               ce_n_d  = 1'b1;
               dqoe_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK: begin
            // With no recovery the master's req is already low by the time IDLE samples it
            ack_d = 1'b0;
            if (HAS_REC) begin
               state_d = S_RECOV;
               cnt_d   = TREC;
            end else begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end
         end
         S_RECOV: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge dev_clk or negedge dev_rst_n) begin
      if (!dev_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         rdata_q <= 32'd0;
         a_q     <= '0;
         dqo_q   <= 8'd0;
         dqoe_q  <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         wr_q    <= 1'b0;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         a_q     <= a_d;
         dqo_q   <= dqo_d;
         dqoe_q  <= dqoe_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         wr_q    <= wr_d;
         wen_q   <= wen_d;
      end
   end

   assign dev.dev_ack   = ack_q;
   assign dev.dev_rdata = rdata_q;
   assign mem_a         = a_q;
   assign mem_dq_o      = dqo_q;
   assign mem_dq_oe     = dqoe_q;
   assign mem_ce_n      = ce_n_q;
   assign mem_oe_n      = oe_n_q;
   assign mem_we_n      = we_n_q;

endmodule
